stream_processing_main: RTL and testbench
=========================================

Name:
stream_processing_main

Overview:
- Self-contained SRAM-to-SRAM stream-processing evaluation top; its only inputs are clock and reset.
- After reset it fills a source SRAM with a known pattern and streams every word through a one-stage add unit into a destination SRAM.
- It then reads back the destination SRAM, checks it against expected values, and reports pass/fail plus cycle counts on status outputs.
- Status outputs may be left unconnected by an enclosing simulation top.

Parameters:
- ADDR_BITS, 10, SRAM address width; DEPTH = 2**ADDR_BITS words.
- DATA_BITS, 32, SRAM word width.
- ADD_VALUE, 1, constant added by the processing stage.
- INIT_SEED, 0, offset used for source pattern generation.

Ports:
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- clk  input  1  single clock; all logic on its rising edge.
- busy  output  1  high from leaving IDLE until DONE.
- done  output  1  high in DONE; sticky until reset.
- error  output  1  valid when done=1; high if err_count != 0.
- err_count  output  ADDR_BITS+1  number of mismatching words.
- run_cycles  output  32  cycles spent in RUN plus DRAIN.

Behaviour:
- Reset value of every output and register is 0; FSM state is IDLE.
- FSM states: IDLE -> INIT -> RUN -> DRAIN -> CHECK -> DONE.
- IDLE: lasts exactly 1 cycle after reset release.
- INIT: one write per cycle, src[a] = (a zero-extended + INIT_SEED) mod 2**DATA_BITS, for a = 0..DEPTH-1; lasts DEPTH cycles.
- RUN:
  - Issues a src read at addresses 0..DEPTH-1, one per cycle; lasts DEPTH cycles.
  - SRAM read latency is 1 cycle.
  - Processing register: out = (rd_data + ADD_VALUE) mod 2**DATA_BITS, with carry discarded.
  - dst write occurs 2 cycles after the corresponding read issue, at the same address, qualified by a delayed valid bit.
- DRAIN: lasts 2 cycles, until the valid pipeline is empty.
- run_cycles increments every RUN/DRAIN cycle; final value = DEPTH+2.
- CHECK:
  - Reads dst at addresses 0..DEPTH-1, one per cycle.
  - Compares each word one cycle later against (a + INIT_SEED + ADD_VALUE) mod 2**DATA_BITS.
  - Each mismatch increments err_count; err_count saturates at all-ones.
  - Lasts DEPTH+1 cycles.
- DONE:
  - done=1, busy=0, error = (err_count != 0).
  - Holds until reset.
  - In simulation only, prints "OK" or "NG err=<n>" once on entry.
- Total from reset release to done: 3*DEPTH+4 cycles.
- Reset mid-operation: all state, counters and outputs return to 0 immediately (asynchronously).
  - SRAM contents are not reset; they are fully rewritten by INIT.
  - After release the sequence restarts from IDLE.
- Address counters wrap at DEPTH-1 -> 0; the FSM leaves the state on the terminal count, never on wrap.
- SRAMs: simple dual-port (1 write port, 1 read port); the same address is never read and written in the same cycle by design.

Decomposition:
- Shared package stream_processing_pkg:
  - FSM state enum;
  - localparam DEPTH;
  - the expected-value function exp_val(addr).
- One sub-module, spu_sram: parameterised simple dual-port synchronous RAM with 1-cycle read; instantiated twice (src, dst).
- FSM, processing stage and checker stay in the top.

Test Plan:
- Default parameters, reset held 50 cycles then released -> done rises exactly 3076 cycles after release; error=0, err_count=0, run_cycles=1026.
- ADDR_BITS=4 -> done after 52 cycles; dst[15] = 16; run_cycles=18.
- DATA_BITS=8, ADD_VALUE=255, INIT_SEED=200 -> sums wrap modulo 256 (dst[0] = 199, dst[60] = 3); error=0.
- Force dst[5] to 0 after RUN completes -> done with error=1, err_count=1.
- Assert reset during RUN (address 300) for 3 cycles -> busy/done/run_cycles go 0 immediately; after release a full sequence completes, done after 3076 cycles, error=0.
- Hold reset asserted for the whole test -> busy=done=error=0 throughout; no SRAM writes occur.

Source files
------------

// File: rtl/stream_processing_pkg.sv
// Shared types, default sizing and the reference pattern for the SRAM-to-SRAM
// stream-processing evaluation top.
package stream_processing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int ADDR_BITS_DEFAULT = 10;
  localparam int DEPTH = 1 << ADDR_BITS_DEFAULT;

  // Word expected at an address; callers truncate to their data width,
  // which gives the modulo-2**DATA_BITS wrap for free.
  function automatic logic [31:0] exp_val(input logic [31:0] addr,
                                          input logic [31:0] seed,
                                          input logic [31:0] add);
    return addr + seed + add;
  endfunction

endpackage

// File: rtl/stream_processing_if.sv
// Status bundle of the stream-processing top; state is exported for debug.
interface stream_processing_if #(
  parameter int ADDR_BITS = 10
);
  import stream_processing_pkg::*;

  logic                 busy;
  logic                 done;
  logic                 error;
  logic [ADDR_BITS:0]   err_count;
  logic [31:0]          run_cycles;
  state_t               state;

  modport master (output busy, done, error, err_count, run_cycles, state);
  modport slave  (input  busy, done, error, err_count, run_cycles, state);

endinterface

// File: rtl/stream_processing_main_sram.sv
// Simple dual-port synchronous RAM: one write port, one read port, 1-cycle read.
module spu_sram
  import stream_processing_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [0:(1 << ADDR_BITS)-1];

  // Array contents are deliberately not reset; INIT rewrites everything.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_processing_main.sv
// Fills src SRAM, streams it through a +ADD_VALUE stage into dst SRAM, then
// reads dst back and reports mismatches and RUN/DRAIN cycle count.
module stream_processing_main
  import stream_processing_pkg::*;
#(
  parameter int          ADDR_BITS = $clog2(DEPTH),
  parameter int          DATA_BITS = 32,
  parameter int unsigned ADD_VALUE = 1,
  parameter int unsigned INIT_SEED = 0
) (
  input  logic clk,
  input  logic reset,
  stream_processing_if.master st
);

  localparam logic [ADDR_BITS-1:0] LAST     = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   ERR_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [DATA_BITS-1:0] ADD_V    = DATA_BITS'(ADD_VALUE);

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr, a1, a2;
  logic                 v1, v2, cv1;
  logic [DATA_BITS-1:0] proc;
  logic [ADDR_BITS:0]   err_cnt;
  logic [31:0]          run_cyc;
  logic                 src_we, src_re, dst_re;
  logic [DATA_BITS-1:0] src_rdata, dst_rdata;
  logic [31:0]          src_pat, chk_pat;

  assign src_pat = exp_val(32'(addr), INIT_SEED, 32'd0);
  assign chk_pat = exp_val(32'(a1), INIT_SEED, ADD_VALUE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Every state is left on a terminal count, never on the address wrap.
  always_comb begin
    state_nxt = state;
    src_we    = 1'b0;
    src_re    = 1'b0;
    dst_re    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_INIT;
      ST_INIT: begin
        src_we = 1'b1;
        if (addr == LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        src_re = 1'b1;
        if (addr == LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (!v1) state_nxt = ST_CHECK;
      ST_CHECK: begin
        dst_re = 1'b1;
        if (cv1 && a1 == LAST) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // v1/a1: read issued last cycle; v2/a2: processed word ready to write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr    <= '0;
      a1      <= '0;
      a2      <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      cv1     <= 1'b0;
      proc    <= '0;
      err_cnt <= '0;
      run_cyc <= '0;
    end else begin
      if (state == ST_INIT || state == ST_RUN || state == ST_CHECK) addr <= addr + ADDR_ONE;
      else                                                          addr <= '0;
      a1   <= addr;
      a2   <= a1;
      v1   <= src_re;
      v2   <= v1;
      cv1  <= dst_re;
      proc <= src_rdata + ADD_V;
      if (state == ST_RUN || state == ST_DRAIN) run_cyc <= run_cyc + 32'd1;
      if (state == ST_CHECK && cv1 && dst_rdata != chk_pat[DATA_BITS-1:0] && err_cnt != '1)
        err_cnt <= err_cnt + ERR_ONE;
    end
  end

  spu_sram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_src (
    .clk   (clk),
    .reset (reset),
    .we    (src_we),
    .waddr (addr),
    .wdata (src_pat[DATA_BITS-1:0]),
    .re    (src_re),
    .raddr (addr),
    .rdata (src_rdata)
  );

  spu_sram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_dst (
    .clk   (clk),
    .reset (reset),
    .we    (v2),
    .waddr (a2),
    .wdata (proc),
    .re    (dst_re),
    .raddr (addr),
    .rdata (dst_rdata)
  );

  assign st.busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign st.done       = (state == ST_DONE);
  assign st.error      = (state == ST_DONE) && (err_cnt != '0);
  assign st.err_count  = err_cnt;
  assign st.run_cycles = run_cyc;
  assign st.state      = state;

endmodule

// File: tb/tb_stream_processing_main.sv
// Directed bench: default, small-depth, wrapping-arithmetic and held-reset
// instances of the stream-processing top, checked against hand-computed values.
module tb_stream_processing_main;
  import stream_processing_pkg::*;

  logic clk = 1'b0;
  logic reset_a = 1'b0, reset_b = 1'b0, reset_c = 1'b0, reset_d = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   quiet_viol = 0;
  logic [31:0] exp_q[$];

  stream_processing_if #(.ADDR_BITS(10)) if_a ();
  stream_processing_if #(.ADDR_BITS(4))  if_b ();
  stream_processing_if #(.ADDR_BITS(6))  if_c ();
  stream_processing_if #(.ADDR_BITS(10)) if_d ();

  stream_processing_main u_a (.clk(clk), .reset(reset_a), .st(if_a));
  stream_processing_main #(.ADDR_BITS(4)) u_b (.clk(clk), .reset(reset_b), .st(if_b));
  stream_processing_main #(.ADDR_BITS(6), .DATA_BITS(8), .ADD_VALUE(255), .INIT_SEED(200))
    u_c (.clk(clk), .reset(reset_c), .st(if_c));
  stream_processing_main u_d (.clk(clk), .reset(reset_d), .st(if_d));

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_d.busy || if_d.done || if_d.error || u_d.src_we || u_d.v2) quiet_viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(obs), 64'(e));
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return if_a.done;
      1:       return if_b.done;
      default: return if_c.done;
    endcase
  endfunction

  // driver tasks
  task automatic set_reset(input int sel, input logic v);
    @(negedge clk);
    case (sel)
      0:       reset_a = v;
      1:       reset_b = v;
      default: reset_c = v;
    endcase
  endtask

  task automatic wait_done(input int sel, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (done_of(sel)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic report_a();
    if (if_a.error) $display("NG err=%0d", if_a.err_count);
    else            $display("OK");
  endtask

  initial begin
    int cyc;

    repeat (50) @(posedge clk);
    #1;
    check("a_reset_busy", 64'(if_a.busy), 64'd0);
    check("a_reset_done", 64'(if_a.done), 64'd0);
    check("a_reset_error", 64'(if_a.error), 64'd0);
    check("a_reset_err_count", 64'(if_a.err_count), 64'd0);
    check("a_reset_run_cycles", 64'(if_a.run_cycles), 64'd0);
    check("a_reset_state", 64'(if_a.state), 64'(ST_IDLE));

    // clean full run
    set_reset(0, 1'b1);
    wait_done(0, 3200, cyc);
    check("a_done_latency", 64'(cyc), 64'd3076);
    report_a();
    check("a_error", 64'(if_a.error), 64'd0);
    check("a_err_count", 64'(if_a.err_count), 64'd0);
    check("a_run_cycles", 64'(if_a.run_cycles), 64'd1026);
    check("a_busy_at_done", 64'(if_a.busy), 64'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1024);
    exp_q.push_back(32'd301);
    sb_check("a_dst0", u_a.u_dst.mem[0]);
    sb_check("a_dst1023", u_a.u_dst.mem[1023]);
    sb_check("a_dst300", u_a.u_dst.mem[300]);

    // corrupted word after RUN/DRAIN
    set_reset(0, 1'b0);
    repeat (3) @(negedge clk);
    set_reset(0, 1'b1);
    repeat (2053) @(posedge clk);
    #1;
    check("a_state_in_check", 64'(if_a.state), 64'(ST_CHECK));
    u_a.u_dst.mem[5] = '0;
    wait_done(0, 1100, cyc);
    check("a_corrupt_latency", 64'(cyc), 64'd1023);
    report_a();
    check("a_corrupt_error", 64'(if_a.error), 64'd1);
    check("a_corrupt_err_count", 64'(if_a.err_count), 64'd1);

    // reset mid-RUN at address 300
    set_reset(0, 1'b0);
    repeat (3) @(negedge clk);
    set_reset(0, 1'b1);
    repeat (1325) @(posedge clk);
    #1;
    check("a_mid_state", 64'(if_a.state), 64'(ST_RUN));
    check("a_mid_addr", 64'(u_a.addr), 64'd300);
    check("a_mid_run_cycles", 64'(if_a.run_cycles), 64'd300);
    reset_a = 1'b0;
    #1;
    check("a_async_busy", 64'(if_a.busy), 64'd0);
    check("a_async_done", 64'(if_a.done), 64'd0);
    check("a_async_run_cycles", 64'(if_a.run_cycles), 64'd0);
    check("a_async_state", 64'(if_a.state), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    set_reset(0, 1'b1);
    wait_done(0, 3200, cyc);
    check("a_restart_latency", 64'(cyc), 64'd3076);
    report_a();
    check("a_restart_error", 64'(if_a.error), 64'd0);

    // small depth
    set_reset(1, 1'b1);
    wait_done(1, 100, cyc);
    check("b_done_latency", 64'(cyc), 64'd52);
    check("b_run_cycles", 64'(if_b.run_cycles), 64'd18);
    check("b_error", 64'(if_b.error), 64'd0);
    exp_q.push_back(32'd16);
    sb_check("b_dst15", 32'(u_b.u_dst.mem[15]));

    // 8-bit data with wrapping sums
    set_reset(2, 1'b1);
    wait_done(2, 300, cyc);
    check("c_done_latency", 64'(cyc), 64'd196);
    check("c_error", 64'(if_c.error), 64'd0);
    exp_q.push_back(32'd199);
    exp_q.push_back(32'd3);
    sb_check("c_dst0", 32'(u_c.u_dst.mem[0]));
    sb_check("c_dst60", 32'(u_c.u_dst.mem[60]));

    // instance held in reset for the whole run
    check("d_quiet_violations", 64'(quiet_viol), 64'd0);
    check("d_state", 64'(if_d.state), 64'(ST_IDLE));
    check("d_err_count", 64'(if_d.err_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
